instr_fetcher: RTL

- Fetch-side responder for the instruction queue's PC request / instruction return interface.
- Accepts one PC per handshake from the instruction queue and looks it up in a small direct-mapped instruction cache.
- On a miss it reads 4 bytes over the shared byte-wide memory port (through the memory arbiter), assembles a little-endian 32-bit instruction, fills the cache and returns the instruction.
- A ROB exception aborts any fetch in progress.

---
 rtl/instr_fetcher_pkg.sv | 23 ++
 rtl/instr_fetcher_icache_dm.sv | 53 +++++
 rtl/instr_fetcher.sv | 119 +++++++++++
 3 files changed

// File: rtl/instr_fetcher_pkg.sv
// rtl/instr_fetcher_pkg.sv - shared widths, state encoding and helpers for the instruction fetcher
package instr_fetcher_pkg;

    localparam int PC_LENGTH         = 32;
    localparam int INSTR_LENGTH      = 32;
    localparam int MEM_DATA_LENGTH   = 8;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam int FETCH_BYTES       = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // Little-endian assembly: the last byte to arrive is the most significant.
    function automatic logic [INSTR_LENGTH-1:0] assemble_instr(
        input logic [MEM_DATA_LENGTH-1:0] last_byte,
        input logic [3*MEM_DATA_LENGTH-1:0] lower_bytes
    );
        return {last_byte, lower_bytes};
    endfunction

endpackage

// File: rtl/instr_fetcher_icache_dm.sv
// rtl/instr_fetcher_icache_dm.sv - direct-mapped instruction cache, one 32-bit word per line
module icache_dm
    import instr_fetcher_pkg::*;
#(
    parameter int IndexBits = ICACHE_INDEX_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PC_LENGTH-1:2]    rd_pc,
    input  logic                    wr_en,
    input  logic [PC_LENGTH-1:2]    wr_pc,
    input  logic [INSTR_LENGTH-1:0] wr_instr,
    output logic                    hit,
    output logic [INSTR_LENGTH-1:0] rd_instr
);

    localparam int Lines   = 1 << IndexBits;
    localparam int TagBits = PC_LENGTH - IndexBits - 2;

    logic [Lines-1:0]        valid;
    logic [TagBits-1:0]      tag_mem  [Lines];
    logic [INSTR_LENGTH-1:0] data_mem [Lines];

    logic [IndexBits-1:0] rd_idx;
    logic [IndexBits-1:0] wr_idx;
    logic [TagBits-1:0]   rd_tag;
    logic [TagBits-1:0]   wr_tag;

    assign rd_idx = rd_pc[IndexBits+1:2];
    assign rd_tag = rd_pc[PC_LENGTH-1:IndexBits+2];
    assign wr_idx = wr_pc[IndexBits+1:2];
    assign wr_tag = wr_pc[PC_LENGTH-1:IndexBits+2];

    assign hit      = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_instr = data_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_instr;
        end
    end

endmodule

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - PC-in / instruction-out fetcher with icache and byte-wide memory refill
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int ICacheIndexBits = ICACHE_INDEX_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       is_exception_from_rob,
    input  logic [PC_LENGTH-1:0]       pc_from_iq,
    input  logic                       is_empty_from_iq,
    output logic                       is_stall_to_iq,
    output logic                       is_finish_to_iq,
    output logic                       is_instr_to_iq,
    output logic [INSTR_LENGTH-1:0]    instr_to_iq,
    output logic                       mem_req_to_arb,
    input  logic                       mem_grant_from_arb,
    output logic [PC_LENGTH-1:0]       mem_a,
    input  logic [MEM_DATA_LENGTH-1:0] mem_din
);

    fetch_state_e state, state_next;

    logic [PC_LENGTH-1:0]         pc_q;
    logic [2:0]                   issued;
    logic [2:0]                   received;
    logic                         pending;
    logic [3*MEM_DATA_LENGTH-1:0] bytes_q;
    logic                         finish_q;
    logic [INSTR_LENGTH-1:0]      instr_q;

    logic                    accept;
    logic                    cache_hit;
    logic [INSTR_LENGTH-1:0] cache_instr;
    logic                    grant_take;
    logic                    last_byte;
    logic                    cache_wr_en;
    logic [INSTR_LENGTH-1:0] fill_instr;

    icache_dm #(
        .IndexBits(ICacheIndexBits)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_pc    (pc_from_iq[PC_LENGTH-1:2]),
        .wr_en    (cache_wr_en),
        .wr_pc    (pc_q[PC_LENGTH-1:2]),
        .wr_instr (fill_instr),
        .hit      (cache_hit),
        .rd_instr (cache_instr)
    );

    assign accept         = (state == IDLE) && !is_empty_from_iq && !is_exception_from_rob;
    assign mem_req_to_arb = (state == FETCH) && (issued != 3'(FETCH_BYTES));
    assign mem_a          = (state == FETCH) ? pc_q + PC_LENGTH'(issued) : '0;
    assign grant_take     = mem_req_to_arb && mem_grant_from_arb;
    // mem_din carries the byte granted on the previous edge whenever pending is set.
    assign last_byte      = (state == FETCH) && pending && (received == 3'(FETCH_BYTES - 1));
    assign cache_wr_en    = last_byte && !is_exception_from_rob;
    assign fill_instr     = assemble_instr(mem_din, bytes_q);

    assign is_stall_to_iq  = (state != IDLE);
    assign is_finish_to_iq = finish_q;
    assign is_instr_to_iq  = finish_q;
    assign instr_to_iq     = instr_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept && !cache_hit) state_next = FETCH;
            FETCH: if (last_byte) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (is_exception_from_rob) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            issued   <= '0;
            received <= '0;
            pending  <= 1'b0;
            bytes_q  <= '0;
            finish_q <= 1'b0;
            instr_q  <= '0;
        end else begin
            state    <= state_next;
            finish_q <= 1'b0;
            if (is_exception_from_rob) begin
                issued   <= '0;
                received <= '0;
                pending  <= 1'b0;
            end else if (state == IDLE) begin
                if (accept && cache_hit) begin
                    finish_q <= 1'b1;
                    instr_q  <= cache_instr;
                end else if (accept) begin
                    pc_q     <= pc_from_iq;
                    issued   <= '0;
                    received <= '0;
                    pending  <= 1'b0;
                end
            end else begin
                pending <= grant_take;
                if (grant_take) issued <= issued + 3'd1;
                if (pending) begin
                    bytes_q  <= {mem_din, bytes_q[3*MEM_DATA_LENGTH-1:MEM_DATA_LENGTH]};
                    received <= received + 3'd1;
                end
                if (last_byte) begin
                    finish_q <= 1'b1;
                    instr_q  <= fill_instr;
                end
            end
        end
    end

endmodule
